// File: rtl/enc_8x3_req.sv
// rtl/enc_8x3_req.sv - registered 8-to-3 request encoder with valid/ready output slot
// Optional feature: define ENC_8X3_ROUND_ROBIN_EN for round-robin selection
// (default build: fixed priority, highest index wins).
module enc_8x3_req (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       E,
  input  logic [7:0] D,
  input  logic       R,
  output logic [2:0] Q,
  output logic       V,
  output logic [7:0] PEND,
  output logic       LOST
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [2:0] q_q, q_d;
  logic       lost_q, lost_d;
  logic [2:0] sel_idx;
  logic       load;
  logic [7:0] clr_mask;
  logic [7:0] set_mask;

`ifdef ENC_8X3_ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] rr_cand;
  logic       rr_found;

  // Round-robin pick: first pending bit after the last presented index, wrapping 7->0
  always_comb begin
    sel_idx  = 3'd0;
    rr_cand  = 3'd0;
    rr_found = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      rr_cand = ptr_q + j[2:0];
      if (!rr_found && pend_q[rr_cand]) begin
        sel_idx  = rr_cand;
        rr_found = 1'b1;
      end
    end
  end
`else
  // Fixed-priority pick: highest pending index wins (later iterations override)
  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pend_q[i]) begin
        sel_idx = i[2:0];
      end
    end
  end
`endif

  // Output-slot FSM, pending update and merge detection; only registered PEND is eligible
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    load    = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (|pend_q) begin
          load    = 1'b1;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (R) begin
          if (|pend_q) begin
            load = 1'b1;
          end else begin
            state_d = S_EMPTY;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (load) begin
      q_d = sel_idx;
    end
    clr_mask = load ? (8'h01 << sel_idx) : 8'h00;
    set_mask = E ? D : 8'h00;
    // A set on the bit being cleared wins, so it becomes a fresh request rather than a loss
    pend_d   = (pend_q & ~clr_mask) | set_mask;
    lost_d   = |(set_mask & pend_q & ~clr_mask);
  end

`ifdef ENC_8X3_ROUND_ROBIN_EN
  // Pointer tracks the most recently loaded index
  always_comb begin
    ptr_d = load ? sel_idx : ptr_q;
  end

  // Pointer register; reset to 7 so the first search starts at index 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 3'd7;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // State, code, pending and loss registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      pend_q  <= 8'h00;
      q_q     <= 3'd0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      q_q     <= q_d;
      lost_q  <= lost_d;
    end
  end

  assign Q    = q_q;
  assign V    = (state_q == S_FULL);
  assign PEND = pend_q;
  assign LOST = lost_q;

endmodule
